lsu_byte_master: RTL and testbench

- Initiator side of the byte-wide data memory: accepts one word load/store request from the CPU datapath and performs it as four sequential single-byte memory accesses.
- Uses big-endian byte order: the byte at addr maps to bits [31:24] and the byte at addr+3 maps to bits [7:0].
- Sits between the MEM stage and the byte-addressed data memory. It owns the memory strobes and returns an assembled read word, or a store completion, through a valid/ready response.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_byte_master.sv | 167 ++++++++++++++++
 tb/tb_lsu_byte_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared FSM states, access-size encodings and beat-count helper for the byte-serial LSU.
// Size encodings only matter to builds with LSU_SIZE_EN defined.
package lsu_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // The reserved size code maps to zero beats, which the master rejects as an error.
  function automatic logic [2:0] sizeBeats(input logic [1:0] size);
    case (size)
      SZ_BYTE: sizeBeats = 3'd1;
      SZ_HALF: sizeBeats = 3'd2;
      SZ_WORD: sizeBeats = 3'(BYTES_PER_WORD);
      default: sizeBeats = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Turns the captured load bytes into the response word.
// With LSU_SIZE_EN defined it sign/zero-extends byte and half loads; otherwise it is a pass-through.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
`ifdef LSU_SIZE_EN
  input  logic [1:0]  i_size,
  input  logic        i_signed,
`endif
  output logic [31:0] o_data
);

`ifdef LSU_SIZE_EN
  // Short loads already sit right-justified in the low lanes; only the upper bits need filling.
  always_comb begin
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & i_word[7]}}, i_word[7:0]};
      SZ_HALF: o_data = {{16{i_signed & i_word[15]}}, i_word[15:0]};
      default: o_data = i_word;
    endcase
  end
`else
  assign o_data = i_word;
`endif

endmodule

// File: rtl/lsu_byte_master.sv
// Big-endian load/store master that performs each CPU request as sequential byte accesses.
// Define LSU_SIZE_EN to add byte/half requests (req_size, req_signed); default is word-only.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
`ifdef LSU_SIZE_EN
  input  logic [1:0]        req_size,
  input  logic              req_signed,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  lsu_state_t      r_state;
  logic [1:0]      r_beat;
  logic [1:0]      r_lastBeat;
  logic            r_write;
  logic [3:0][7:0] r_wdata;
  logic [3:0][7:0] r_lanes;

  logic [3:0][7:0] w_reqBytes;
  logic [1:0]      w_size;
  logic [2:0]      w_beats;
  logic [1:0]      w_reqLast;
  logic [1:0]      w_lane;
  logic [1:0]      w_nextLane;
  logic [ADDR_W:0] w_endAddr;
  logic            w_aligned;
  logic            w_inRange;
  logic            w_legal;
  logic [31:0]     w_loadData;

`ifdef LSU_SIZE_EN
  logic [1:0]      r_size;
  logic            r_signed;
  assign w_size = req_size;
`else
  assign w_size = SZ_WORD;
`endif

  assign w_reqBytes = req_wdata;
  assign w_beats    = sizeBeats(w_size);
  assign w_reqLast  = w_beats[1:0] - 2'd1;
  // One extra bit so an access running past 2^ADDR_W cannot wrap back into range.
  assign w_endAddr  = {1'b0, req_addr} + (ADDR_W+1)'(w_beats) - (ADDR_W+1)'(1);
  assign w_inRange  = (w_endAddr <= (ADDR_W+1)'(MEM_BYTES - 1));
  assign w_legal    = (w_beats != 3'd0) && w_aligned && w_inRange;

  always_comb begin
    case (w_size)
      SZ_BYTE: w_aligned = 1'b1;
      SZ_HALF: w_aligned = ~req_addr[0];
      SZ_WORD: w_aligned = (req_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Beat 0 carries the most significant byte of the access, so lanes count down.
  assign w_lane     = r_lastBeat - r_beat;
  assign w_nextLane = w_lane - 2'd1;

  lsu_load_align u_loadAlign (
    .i_word   (r_lanes),
`ifdef LSU_SIZE_EN
    .i_size   (r_size),
    .i_signed (r_signed),
`endif
    .o_data   (w_loadData)
  );

  assign resp_rdata = (r_state == RESP && !r_write && !resp_err) ? w_loadData : 32'd0;

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_beat     <= 2'd0;
      r_lastBeat <= 2'd0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_lanes    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
`ifdef LSU_SIZE_EN
      r_size     <= SZ_WORD;
      r_signed   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r_write    <= req_write;
            r_wdata    <= w_reqBytes;
            r_lanes    <= '0;
            r_beat     <= 2'd0;
            r_lastBeat <= w_reqLast;
            req_ready  <= 1'b0;
`ifdef LSU_SIZE_EN
            r_size     <= req_size;
            r_signed   <= req_signed;
`endif
            if (w_legal) begin
              r_state   <= XFER;
              mem_addr  <= req_addr;
              mem_re    <= ~req_write;
              mem_we    <= req_write;
              mem_wdata <= req_write ? w_reqBytes[w_reqLast] : 8'd0;
            end else begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
          end
        end
        XFER: begin
          if (!r_write) begin
            r_lanes[w_lane] <= mem_rdata;
          end
          if (r_beat == r_lastBeat) begin
            r_state    <= RESP;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end else begin
            r_beat    <= r_beat + 2'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= r_write ? r_wdata[w_nextLane] : 8'd0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state    <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed scoreboard bench for lsu_byte_master against a 128-byte memory model.
// Build with LSU_SIZE_EN defined to also exercise byte/half accesses.
module tb_lsu_byte_master;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 32;

  logic              clock_in = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
`ifdef LSU_SIZE_EN
  logic [1:0]        req_size = SZ_WORD;
  logic              req_signed = 1'b0;
`endif
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptCycle;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } beat_t;

  resp_t      respQ[$];
  beat_t      beatQ[$];
  logic [7:0] mem [0:MEM_BYTES-1];
  int         cycles = 0;
  int         checks = 0;
  int         errors = 0;
  bit         headSeen = 1'b0;

  lsu_byte_master #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef LSU_SIZE_EN
    .req_size   (req_size),
    .req_signed (req_signed),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cycles <= cycles + 1;

  // Byte memory: combinational read, write committed at the clock edge.
  assign mem_rdata = (mem_re && mem_addr < 32'(MEM_BYTES)) ? mem[mem_addr[6:0]] : 8'h00;

  always @(posedge clock_in) begin
    if (mem_we && mem_addr < 32'(MEM_BYTES)) mem[mem_addr[6:0]] = mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event, want none/earlier", name);
  endtask

  task automatic waitCycle();
    @(posedge clock_in);
    #2;
  endtask

  // Every memory strobe must match the next expected beat, in order.
  always @(negedge clock_in) begin : beatMonitor
    beat_t b;
    if (mem_re || mem_we) begin
      if (beatQ.size() == 0) begin
        reportFail("unexpected_mem_strobe");
      end else begin
        b = beatQ.pop_front();
        checkOutput("beat_addr", mem_addr, b.addr);
        checkOutput("beat_strobes", {30'd0, mem_we, mem_re}, {30'd0, b.we, ~b.we});
        if (b.we) checkOutput("beat_wdata", {24'd0, mem_wdata}, {24'd0, b.data});
      end
    end
  end

  // Responses are checked on every valid cycle, so held data is re-verified under backpressure.
  always @(negedge clock_in) begin : respMonitor
    resp_t r;
    if (resp_valid) begin
      if (respQ.size() == 0) begin
        reportFail("unexpected_resp");
      end else begin
        r = respQ[0];
        if (!headSeen) begin
          checkOutput("resp_latency", 32'(cycles - r.acceptCycle), 32'(r.lat));
          headSeen = 1'b1;
        end
        checkOutput("resp_rdata", resp_rdata, r.rdata);
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, r.err});
        if (resp_ready) begin
          void'(respQ.pop_front());
          headSeen = 1'b0;
        end
      end
    end
  end

  // Issues one request and queues its expected beats and response; nBeats==0 means rejected.
  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic sgn, input int nBeats,
                               input logic [31:0] expRdata, input logic expErr);
    resp_t r;
    beat_t b;
    int    waitCount = 0;
    while (!req_ready && waitCount < 50) begin
      waitCycle();
      waitCount++;
    end
    if (!req_ready) begin
      reportFail("req_ready_timeout");
      return;
    end
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef LSU_SIZE_EN
    req_size   = size;
    req_signed = sgn;
`endif
    r.rdata       = expRdata;
    r.err         = expErr;
    r.acceptCycle = cycles;
    r.lat         = (nBeats == 0) ? 1 : nBeats + 1;
    respQ.push_back(r);
    for (int i = 0; i < nBeats; i++) begin
      b.addr = addr + 32'(i);
      b.we   = write;
      b.data = 8'(wdata >> (8 * (nBeats - 1 - i)));
      beatQ.push_back(b);
    end
    waitCycle();
    req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((respQ.size() != 0 || beatQ.size() != 0) && n < 100) begin
      waitCycle();
      n++;
    end
    if (respQ.size() != 0 || beatQ.size() != 0) begin
      reportFail("drain_timeout");
      respQ.delete();
      beatQ.delete();
      headSeen = 1'b0;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);

    // Reset values while reset is held low.
    repeat (3) waitCycle();
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_mem_strobes", {30'd0, mem_we, mem_re}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    reset = 1'b1;
    waitCycle();

    // Basic word load.
    applyStimulus(1'b0, 32'h4, 32'h0, SZ_WORD, 1'b0, 4, 32'h04050607, 1'b0);
    waitDrain();

    // Store then read back.
    applyStimulus(1'b1, 32'h8, 32'hDEADBEEF, SZ_WORD, 1'b0, 4, 32'h0, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h8, 32'h0, SZ_WORD, 1'b0, 4, 32'hDEADBEEF, 1'b0);
    waitDrain();

    // Alignment and range edges.
    applyStimulus(1'b0, 32'h6, 32'h0, SZ_WORD, 1'b0, 0, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 32'h7C, 32'h0, SZ_WORD, 1'b0, 4, 32'h7C7D7E7F, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h7E, 32'h0, SZ_WORD, 1'b0, 0, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 32'hFFFFFFFC, 32'h0, SZ_WORD, 1'b0, 0, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, 32'h80, 32'h12345678, SZ_WORD, 1'b0, 0, 32'h0, 1'b1);
    waitDrain();

    // Response backpressure with an ignored request pending.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 32'h8, 32'h0, SZ_WORD, 1'b0, 4, 32'hDEADBEEF, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      waitCycle();
      n++;
    end
    if (!resp_valid) reportFail("bp_resp_timeout");
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'hCAFEF00D;
      checkOutput("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
      waitCycle();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    checkOutput("bp_resp_still_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("bp_req_ready_handshake", {31'd0, req_ready}, 32'd0);
    waitCycle();
    checkOutput("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    checkOutput("bp_resp_dropped", {31'd0, resp_valid}, 32'd0);
    waitDrain();
    checkOutput("bp_ignored_not_written", {24'd0, mem[32]}, 32'h20);

    // Reset lands at the edge ending beat 1 of a store.
    applyStimulus(1'b1, 32'h10, 32'hA1B2C3D4, SZ_WORD, 1'b0, 4, 32'h0, 1'b0);
    waitCycle();
    reset = 1'b0;
    waitCycle();
    checkOutput("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_mid_beats_left", 32'(beatQ.size()), 32'd2);
    respQ.delete();
    beatQ.delete();
    headSeen = 1'b0;
    reset = 1'b1;
    waitCycle();
    checkOutput("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_mid_byte0", {24'd0, mem[16]}, 32'hA1);
    checkOutput("rst_mid_byte1", {24'd0, mem[17]}, 32'hB2);
    checkOutput("rst_mid_byte2", {24'd0, mem[18]}, 32'h12);
    checkOutput("rst_mid_byte3", {24'd0, mem[19]}, 32'h13);
    waitCycle();
    checkOutput("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);

    // Load after the aborted store starts cleanly.
    applyStimulus(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 4, 32'hA1B21213, 1'b0);
    waitDrain();

`ifdef LSU_SIZE_EN
    // Sized accesses with sign/zero extension.
    mem[5] = 8'h85;
    applyStimulus(1'b0, 32'h5, 32'h0, SZ_BYTE, 1'b1, 1, 32'hFFFFFF85, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h5, 32'h0, SZ_BYTE, 1'b0, 1, 32'h00000085, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h5, 32'h0, SZ_HALF, 1'b1, 0, 32'h0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 32'h4, 32'h0, SZ_HALF, 1'b1, 2, 32'h00000485, 1'b0);
    waitDrain();
    applyStimulus(1'b1, 32'h30, 32'h0000BEEF, SZ_HALF, 1'b0, 2, 32'h0, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h30, 32'h0, SZ_HALF, 1'b1, 2, 32'hFFFFBEEF, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h7F, 32'h0, SZ_BYTE, 1'b0, 1, 32'h0000007F, 1'b0);
    waitDrain();
    applyStimulus(1'b0, 32'h4, 32'h0, 2'd3, 1'b0, 0, 32'h0, 1'b1);
    waitDrain();
`endif

    waitDrain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
